// File: rtl/fft_frame_feeder_if.sv
// Sample stream bundle for fft_frame_feeder: the upstream valid/ready sample port
// and the registered FFT-side burst outputs.
interface fft_frame_feeder_if #(
  parameter int DW = 20
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_real;
  logic [DW-1:0] in_imag;
  logic [DW-1:0] realin;
  logic [DW-1:0] imagin;
  logic          startin;
  logic          burst;
  logic [15:0]   frame_cnt;

  modport master (
    output in_valid, in_real, in_imag,
    input  in_ready, realin, imagin, startin, burst, frame_cnt
  );

  modport slave (
    input  in_valid, in_real, in_imag,
    output in_ready, realin, imagin, startin, burst, frame_cnt
  );
endinterface

// File: rtl/fft_frame_feeder.sv
// Ping-pong frame buffer that collects N complex samples per bank and replays
// each full bank to the FFT input as one unbroken burst.
module fft_frame_feeder #(
  parameter int DW  = 20,
  parameter int N   = 256,
  parameter int GAP = 0
) (
  input logic              clk,
  input logic              reset,
  fft_frame_feeder_if.slave bus
);
  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);
  localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BURST,
    S_GAP
  } state_t;

  logic [2*DW-1:0] mem [2*N];

  state_t          state_q,     state_d;
  logic            wb_q,        wb_d;
  logic [AW-1:0]   wi_q,        wi_d;
  logic            rb_q,        rb_d;
  logic [AW-1:0]   ri_q,        ri_d;
  logic [1:0]      full_q,      full_d;
  logic [3:0]      gap_cnt_q,   gap_cnt_d;
  logic            rdy_en_q,    rdy_en_d;
  logic [DW-1:0]   realin_q,    realin_d;
  logic [DW-1:0]   imagin_q,    imagin_d;
  logic            startin_q,   startin_d;
  logic            burst_q,     burst_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;

  logic            in_ready;
  logic            wr_en;
  logic [2*DW-1:0] rd_word;

  // rdy_en_q holds in_ready low through reset and until the first clock edge after it.
  assign in_ready = rdy_en_q & ~full_q[wb_q];
  assign wr_en    = bus.in_valid & in_ready;
  assign rd_word  = mem[{rb_q, ri_q}];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wb_q, wi_q}] <= {bus.in_real, bus.in_imag};
    end
  end

  always_comb begin
    state_d     = state_q;
    wb_d        = wb_q;
    wi_d        = wi_q;
    rb_d        = rb_q;
    ri_d        = ri_q;
    full_d      = full_q;
    gap_cnt_d   = gap_cnt_q;
    rdy_en_d    = 1'b1;
    realin_d    = '0;
    imagin_d    = '0;
    startin_d   = 1'b0;
    burst_d     = 1'b0;
    frame_cnt_d = frame_cnt_q;

    // A write only ever targets an empty bank and a burst only ever drains a full
    // one, so the set and clear below never land on the same flag.
    if (wr_en) begin
      wi_d = wi_q + AW'(1);
      if (wi_q == LAST) begin
        full_d[wb_q] = 1'b1;
        wb_d         = ~wb_q;
        wi_d         = '0;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (full_q[rb_q]) begin
          state_d = S_BURST;
          ri_d    = '0;
        end
      end
      S_GAP: begin
        if (gap_cnt_q != 4'd0) begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end else if (full_q[rb_q]) begin
          state_d = S_BURST;
          ri_d    = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BURST: begin
        realin_d  = rd_word[2*DW-1:DW];
        imagin_d  = rd_word[DW-1:0];
        startin_d = (ri_q == '0);
        burst_d   = 1'b1;
        ri_d      = ri_q + AW'(1);
        if (ri_q == LAST) begin
          full_d[rb_q] = 1'b0;
          rb_d         = ~rb_q;
          ri_d         = '0;
          frame_cnt_d  = frame_cnt_q + 16'd1;
          if (GAP > 0) begin
            state_d   = S_GAP;
            gap_cnt_d = GAP_LOAD;
          end else if (full_q[~rb_q]) begin
            state_d = S_BURST;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wb_q        <= 1'b0;
      wi_q        <= '0;
      rb_q        <= 1'b0;
      ri_q        <= '0;
      full_q      <= 2'b00;
      gap_cnt_q   <= 4'd0;
      rdy_en_q    <= 1'b0;
      realin_q    <= '0;
      imagin_q    <= '0;
      startin_q   <= 1'b0;
      burst_q     <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      wb_q        <= wb_d;
      wi_q        <= wi_d;
      rb_q        <= rb_d;
      ri_q        <= ri_d;
      full_q      <= full_d;
      gap_cnt_q   <= gap_cnt_d;
      rdy_en_q    <= rdy_en_d;
      realin_q    <= realin_d;
      imagin_q    <= imagin_d;
      startin_q   <= startin_d;
      burst_q     <= burst_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.realin    = realin_q;
  assign bus.imagin    = imagin_q;
  assign bus.startin   = startin_q;
  assign bus.burst     = burst_q;
  assign bus.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_fft_frame_feeder.sv
// Scoreboard bench for fft_frame_feeder: one instance with no inter-burst gap and
// one with a 15-cycle gap, both checked against the order samples were accepted.
module tb_fft_frame_feeder;
  localparam int DW = 20;
  localparam int N  = 256;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int checks = 0;
  int errors = 0;

  fft_frame_feeder_if #(.DW(DW)) bus0 ();
  fft_frame_feeder_if #(.DW(DW)) bus15 ();

  fft_frame_feeder #(.DW(DW), .N(N), .GAP(0)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  fft_frame_feeder #(.DW(DW), .N(N), .GAP(15)) u_dut15 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus15.slave)
  );

  always #5 clk = ~clk;

  logic [2*DW-1:0] q0[$];
  logic [2*DW-1:0] q15[$];
  logic [2*DW-1:0] exp0, exp15;
  int idx0 = 0, idx15 = 0;
  int starts0 = 0, starts15 = 0;
  int bcyc0 = 0, bcyc15 = 0;
  int idle15 = 0;
  int gaps15[$];
  int drv_acc = 0;

  // Every accepted upstream sample becomes the next expected burst word.
  always @(posedge clk) begin
    if (reset === 1'b0) begin
      if (bus0.in_valid === 1'b1 && bus0.in_ready === 1'b1)
        q0.push_back({bus0.in_real, bus0.in_imag});
      if (bus15.in_valid === 1'b1 && bus15.in_ready === 1'b1)
        q15.push_back({bus15.in_real, bus15.in_imag});
    end
  end

  always @(negedge clk) begin
    if (reset !== 1'b0) begin
      idx0 = 0;
    end else if (bus0.burst === 1'b1) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL sb0_data got=%h/%h required=none pending", bus0.realin, bus0.imagin);
      end else begin
        exp0 = q0.pop_front();
        if ({bus0.realin, bus0.imagin} !== exp0) begin
          errors++;
          $display("FAIL sb0_data got=%h required=%h idx=%0d", {bus0.realin, bus0.imagin}, exp0, idx0);
        end
      end
      checks++;
      if (bus0.startin !== (idx0 == 0)) begin
        errors++;
        $display("FAIL sb0_startin got=%b required=%b idx=%0d", bus0.startin, (idx0 == 0), idx0);
      end
      if (idx0 == 0) starts0++;
      idx0 = (idx0 + 1) % N;
      bcyc0++;
    end else begin
      checks++;
      if (idx0 != 0 || bus0.burst !== 1'b0 || bus0.startin !== 1'b0 ||
          bus0.realin !== '0 || bus0.imagin !== '0) begin
        errors++;
        $display("FAIL sb0_idle burst=%b startin=%b realin=%h imagin=%h idx=%0d required=0/0/0/0 idx 0",
                 bus0.burst, bus0.startin, bus0.realin, bus0.imagin, idx0);
        idx0 = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (reset !== 1'b0) begin
      idx15  = 0;
      idle15 = 0;
    end else if (bus15.burst === 1'b1) begin
      checks++;
      if (q15.size() == 0) begin
        errors++;
        $display("FAIL sb15_data got=%h/%h required=none pending", bus15.realin, bus15.imagin);
      end else begin
        exp15 = q15.pop_front();
        if ({bus15.realin, bus15.imagin} !== exp15) begin
          errors++;
          $display("FAIL sb15_data got=%h required=%h idx=%0d", {bus15.realin, bus15.imagin}, exp15, idx15);
        end
      end
      checks++;
      if (bus15.startin !== (idx15 == 0)) begin
        errors++;
        $display("FAIL sb15_startin got=%b required=%b idx=%0d", bus15.startin, (idx15 == 0), idx15);
      end
      if (idx15 == 0) begin
        if (starts15 > 0) gaps15.push_back(idle15);
        starts15++;
      end
      idle15 = 0;
      idx15  = (idx15 + 1) % N;
      bcyc15++;
    end else begin
      checks++;
      if (idx15 != 0 || bus15.burst !== 1'b0 || bus15.startin !== 1'b0 ||
          bus15.realin !== '0 || bus15.imagin !== '0) begin
        errors++;
        $display("FAIL sb15_idle burst=%b startin=%b realin=%h imagin=%h idx=%0d required=0/0/0/0 idx 0",
                 bus15.burst, bus15.startin, bus15.realin, bus15.imagin, idx15);
        idx15 = 0;
      end
      idle15++;
    end
  end

  task automatic clear_counters();
    q0.delete();
    q15.delete();
    gaps15.delete();
    starts0  = 0;
    starts15 = 0;
    bcyc0    = 0;
    bcyc15   = 0;
    drv_acc  = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_counters();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // ramp=1 sends real=n, imag=-n; otherwise random words. duty is the valid percentage.
  task automatic drive(input int sel, input int nsamp, input int duty, input bit ramp);
    int n = 0;
    int cyc = 0;
    bit v;
    logic [DW-1:0] r, im;
    while (n < nsamp && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      v  = ($urandom_range(99) < duty);
      r  = ramp ? DW'(n) : DW'($urandom);
      im = ramp ? DW'(-n) : DW'($urandom);
      if (sel == 0) begin
        bus0.in_valid = v; bus0.in_real = r; bus0.in_imag = im;
        if (v && bus0.in_ready === 1'b1) n++;
      end else begin
        bus15.in_valid = v; bus15.in_real = r; bus15.in_imag = im;
        if (v && bus15.in_ready === 1'b1) n++;
      end
      drv_acc = n;
    end
    @(posedge clk);
    #1;
    bus0.in_valid  = 1'b0;
    bus15.in_valid = 1'b0;
    checks++;
    if (n != nsamp) begin
      errors++;
      $display("FAIL drive_timeout accepted=%0d required=%0d", n, nsamp);
    end
  endtask

  task automatic wait_drain(input int sel);
    int cyc = 0;
    while (cyc < 3000 && ((sel == 0) ? (q0.size() != 0 || bus0.burst !== 1'b0)
                                     : (q15.size() != 0 || bus15.burst !== 1'b0))) begin
      @(negedge clk);
      cyc++;
    end
    repeat (20) @(negedge clk);
    checks++;
    if (cyc >= 3000) begin
      errors++;
      $display("FAIL drain_timeout sel=%0d pending=%0d required=0", sel, (sel == 0) ? q0.size() : q15.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_counters();
    @(posedge clk);
    #1;
    checks++;
    if (bus0.in_ready !== 1'b0 || bus15.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready got=%b/%b required=0/0", bus0.in_ready, bus15.in_ready);
    end
    checks++;
    if ({bus0.realin, bus0.imagin, bus0.startin, bus0.burst, bus0.frame_cnt} !== '0 ||
        {bus15.realin, bus15.imagin, bus15.startin, bus15.burst, bus15.frame_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got0=%h/%h/%b/%b/%0d required=all 0",
               bus0.realin, bus0.imagin, bus0.startin, bus0.burst, bus0.frame_cnt);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (bus0.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge got=%b required=0", bus0.in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus0.in_ready !== 1'b1 || bus15.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_edge got=%b/%b required=1/1", bus0.in_ready, bus15.in_ready);
    end
  endtask

  task automatic test_single_frame();
    drive(0, N, 100, 1'b1);
    @(posedge clk);
    #1;
    checks++;
    if (bus0.burst !== 1'b0) begin
      errors++;
      $display("FAIL latency_k1 burst=%b required=0", bus0.burst);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus0.startin !== 1'b1 || bus0.burst !== 1'b1 || bus0.realin !== 20'h00000 || bus0.imagin !== 20'h00000) begin
      errors++;
      $display("FAIL first_sample got=%h/%h s=%b b=%b required=00000/00000 s=1 b=1",
               bus0.realin, bus0.imagin, bus0.startin, bus0.burst);
    end
    repeat (N - 1) @(posedge clk);
    #1;
    checks++;
    if (bus0.realin !== 20'h000FF || bus0.imagin !== 20'hFFF01 || bus0.startin !== 1'b0) begin
      errors++;
      $display("FAIL last_sample got=%h/%h s=%b required=000ff/fff01 s=0", bus0.realin, bus0.imagin, bus0.startin);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus0.burst !== 1'b0 || bus0.startin !== 1'b0 || bus0.realin !== '0 || bus0.imagin !== '0) begin
      errors++;
      $display("FAIL after_burst got=%h/%h s=%b b=%b required=all 0", bus0.realin, bus0.imagin, bus0.startin, bus0.burst);
    end
    checks++;
    if (bus0.frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL single_frame_cnt got=%0d required=1", bus0.frame_cnt);
    end
    wait_drain(0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(0, 4 * N, 100, 1'b0);
    wait_drain(0);
    checks++;
    if (bus0.frame_cnt !== 16'd4) begin
      errors++;
      $display("FAIL stream_frame_cnt got=%0d required=4", bus0.frame_cnt);
    end
    checks++;
    if (starts0 != 4 || bcyc0 != 4 * N) begin
      errors++;
      $display("FAIL stream_bursts starts=%0d cycles=%0d required=4/1024", starts0, bcyc0);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    fork
      drive(1, 3 * N, 100, 1'b0);
      begin
        int cyc = 0;
        while (drv_acc < 2 * N && cyc < 2000) begin
          @(posedge clk);
          #1;
          cyc++;
        end
        checks++;
        if (bus15.in_ready !== 1'b0 || bus15.burst !== 1'b1) begin
          errors++;
          $display("FAIL bp_drop in_ready=%b burst=%b required=0/1", bus15.in_ready, bus15.burst);
        end
        cyc = 0;
        while (bus15.in_ready !== 1'b1 && cyc < 600) begin
          @(posedge clk);
          #1;
          cyc++;
        end
        checks++;
        if (bus15.burst !== 1'b1 || bus15.startin !== 1'b0 || idx15 != N - 1) begin
          errors++;
          $display("FAIL bp_rise burst=%b idx=%0d required=1 at idx %0d", bus15.burst, idx15, N - 1);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus15.burst !== 1'b0 || bus15.in_ready !== 1'b1) begin
          errors++;
          $display("FAIL bp_after burst=%b in_ready=%b required=0/1", bus15.burst, bus15.in_ready);
        end
      end
    join
    wait_drain(1);
    checks++;
    if (bus15.frame_cnt !== 16'd3 || starts15 != 3) begin
      errors++;
      $display("FAIL bp_frames got=%0d starts=%0d required=3/3", bus15.frame_cnt, starts15);
    end
    checks++;
    if (gaps15.size() != 2 || gaps15[0] != 15 || gaps15[gaps15.size() - 1] != 15) begin
      errors++;
      $display("FAIL bp_gap count=%0d first=%0d required=2 gaps of 15",
               gaps15.size(), (gaps15.size() > 0) ? gaps15[0] : -1);
    end
  endtask

  task automatic test_sparse();
    do_reset();
    drive(0, 2 * N, 30, 1'b0);
    wait_drain(0);
    checks++;
    if (bus0.frame_cnt !== 16'd2 || starts0 != 2 || bcyc0 != 2 * N) begin
      errors++;
      $display("FAIL sparse_frames got=%0d starts=%0d cycles=%0d required=2/2/512", bus0.frame_cnt, starts0, bcyc0);
    end
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    do_reset();
    drive(0, N + 50, 100, 1'b0);
    while (idx0 < 100 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus0.realin, bus0.imagin, bus0.startin, bus0.burst, bus0.in_ready, bus0.frame_cnt} !== '0) begin
      errors++;
      $display("FAIL async_reset got=%h/%h s=%b b=%b r=%b f=%0d required=all 0",
               bus0.realin, bus0.imagin, bus0.startin, bus0.burst, bus0.in_ready, bus0.frame_cnt);
    end
    clear_counters();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    drive(0, N, 100, 1'b0);
    wait_drain(0);
    checks++;
    if (bus0.frame_cnt !== 16'd1 || starts0 != 1 || bcyc0 != N) begin
      errors++;
      $display("FAIL fresh_frame got=%0d starts=%0d cycles=%0d required=1/1/256", bus0.frame_cnt, starts0, bcyc0);
    end
  endtask

  initial begin
    bus0.in_valid  = 1'b0;
    bus0.in_real   = '0;
    bus0.in_imag   = '0;
    bus15.in_valid = 1'b0;
    bus15.in_real  = '0;
    bus15.in_imag  = '0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_backpressure();
    test_sparse();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time=%0t required=finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
